booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Sequential signed (two's-complement) radix-2 Booth multiplier: WIDTH x WIDTH operands in, 2*WIDTH product out.
- Accepts one operation per start pulse and retires one Booth iteration per clock.
- Serves as the datapath's area-lean multiply unit in place of a combinational array multiplier.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 4..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- M  input  WIDTH  multiplicand, signed two's complement
- Q  input  WIDTH  multiplier, signed two's complement
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse when P becomes valid
- P  output  2*WIDTH  signed product, registered

Behaviour:
- Reset (synchronous, active-high, priority over all else): state=IDLE, P=0, done=0, busy=0, internal A/Q/q-1/count cleared.
- Reset during RUN aborts the operation: no done pulse, P=0.
- States:
  - IDLE: start=1 at edge k latches M into the multiplicand register (sign-extended to WIDTH+1), A=0, Qreg=Q, q-1=0, count=WIDTH; go RUN; busy=1 from edge k.
  - RUN: each edge examines {Qreg[0],q-1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add. Then arithmetic-shift-right {A,Qreg,q-1} by one, decrement count.
  - Completion: on the edge where count reaches 0 (edge k+WIDTH), P={A[WIDTH-1:0],Qreg}, done=1, busy=0, state=IDLE.
- done deasserts on the next edge.
- P holds its value until the next completion or reset.
- Latency: P valid and done high WIDTH cycles after the start-sampling edge (32 for the default).
- start while busy=1 is ignored; inputs M/Q are don't-care after the start-sampling edge.
- start may be asserted in the same cycle done is high; it is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.
- Accumulator A is WIDTH+1 bits so the most-negative operand pair (-2^(WIDTH-1) squared = 2^(2*WIDTH-2)) is exact; no overflow is possible in P.

Optional Feature:
- Macro MULT_OVF_FLAG_EN.
- Defined: adds output ovf (1 bit), registered with P on completion. ovf=1 when P is not representable as a signed WIDTH-bit value, i.e. P[2*WIDTH-1:WIDTH-1] is not all-equal. ovf is cleared by reset and holds with P.
- Undefined: port ovf and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package mult_pkg holds the state enum (IDLE, RUN) and the default WIDTH constant.
- One sub-module, booth_step: a combinational single iteration taking A, Qreg, q-1 and M and returning the next A, Qreg and q-1. The top instantiates it once, with the FSM and registers in the top.

Test Plan:
- M=-2, Q=8, start pulse -> done exactly 32 cycles later, P=64'hFFFF_FFFF_FFFF_FFF0 (-16).
- M=32'h8000_0000, Q=32'h8000_0000 -> P=64'h4000_0000_0000_0000; ovf=1 if MULT_OVF_FLAG_EN.
- M=32'h7FFF_FFFF, Q=32'h7FFF_FFFF -> P=64'h3FFF_FFFF_0000_0001; M=-1, Q=-1 -> P=1, ovf=0.
- start re-pulsed at cycle 5 of a run with different M/Q -> ignored; first result unchanged, exactly one done.
- reset asserted at cycle 10 of a run -> next edge busy=0, P=0, no done; a new start afterwards yields the correct product.
- Back-to-back: start held high continuously with M=3, Q=-5 then M=0, Q=123 -> P=-15 then 0, done pulses 33 cycles apart.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : mult_pkg

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand followed by an arithmetic shift right of {A, Qreg, q-1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
    o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    o_q1 = i_q[0];
  end

endmodule : booth_step

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one iteration per clock.
// Optional overflow flag output enabled by defining MULT_OVF_FLAG_EN.
module booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
`ifdef MULT_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH:0]     r_a, w_a_nxt, r_m, w_m_nxt;
  logic [WIDTH-1:0]   r_q, w_q_nxt;
  logic               r_q1, w_q1_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic [2*WIDTH-1:0] r_p, w_p_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ovf, w_ovf_nxt;

  logic [WIDTH:0]     w_a_step;
  logic [WIDTH-1:0]   w_q_step;
  logic               w_q1_step;
  logic [2*WIDTH-1:0] w_p_final;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_step),
    .o_q  (w_q_step),
    .o_q1 (w_q1_step)
  );

  // A is one bit wider than needed for the product; its top bit is only sign headroom.
  assign w_p_final = {w_a_step[WIDTH-1:0], w_q_step};

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_m_nxt     = r_m;
    w_q_nxt     = r_q;
    w_q1_nxt    = r_q1;
    w_count_nxt = r_count;
    w_p_nxt     = r_p;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_m_nxt     = {M[WIDTH-1], M};
          w_a_nxt     = '0;
          w_q_nxt     = Q;
          w_q1_nxt    = 1'b0;
          w_count_nxt = CW'(WIDTH);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_a_nxt     = w_a_step;
        w_q_nxt     = w_q_step;
        w_q1_nxt    = w_q1_step;
        w_count_nxt = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_p_nxt     = w_p_final;
          w_done_nxt  = 1'b1;
          w_ovf_nxt   = !((&w_p_final[2*WIDTH-1:WIDTH-1]) || !(|w_p_final[2*WIDTH-1:WIDTH-1]));
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_m     <= w_m_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_count <= w_count_nxt;
      r_p     <= w_p_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign P    = r_p;

`ifdef MULT_OVF_FLAG_EN
  assign ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf;
`endif

endmodule : booth_multiplier

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (WIDTH=32): directed product table
// plus hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_booth_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   M;
  logic [W-1:0]   Q;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;
`ifdef MULT_OVF_FLAG_EN
  logic           ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .M     (M),
    .Q     (Q),
    .busy  (busy),
    .done  (done),
    .P     (P)
`ifdef MULT_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
    logic           ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done, returning the number of rising edges seen (-1 on timeout).
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                       input logic [2*W-1:0] exp_p, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    M = m;
    Q = q;
    @(posedge clk);
    #1;
    check({name, " busy after start"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    M = 32'hDEAD_BEEF;
    Q = 32'h1234_5678;
    wait_done(40, cyc);
    check({name, " latency"}, 64'(cyc), 64'd32);
    check({name, " P"}, P, exp_p);
    check({name, " busy at done"}, 64'(busy), 64'd0);
`ifdef MULT_OVF_FLAG_EN
    check({name, " ovf"}, 64'(ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x flag in vector");
`endif
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, 64'(done), 64'd0);
    check({name, " P holds"}, P, exp_p);
  endtask

  initial begin
    int ndone;
    int first_cyc;
    int cyc;
    logic [2*W-1:0] p_at_done;

    vecs[0] = '{-32'sd2, 32'd8, -64'sd16, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
    vecs[3] = '{-32'sd1, -32'sd1, 64'd1, 1'b0};
    vecs[4] = '{32'd3, -32'sd5, -64'sd15, 1'b0};
    vecs[5] = '{32'd0, 32'd123, 64'd0, 1'b0};
    vecs[6] = '{32'd12345, -32'sd678, -64'sd8369910, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[8] = '{32'h8000_0000, -32'sd1, 64'h0000_0000_8000_0000, 1'b1};
    vecs[9] = '{32'd65536, 32'd65536, 64'h0000_0001_0000_0000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    M = '0;
    Q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset P", P, 64'd0);
`ifdef MULT_OVF_FLAG_EN
    check("reset ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].ovf);
    end

    // start re-pulsed mid-run with different operands must be ignored
    @(negedge clk);
    start = 1'b1;
    M = 32'd7;
    Q = 32'd6;
    @(posedge clk);
    ndone = 0;
    first_cyc = -1;
    p_at_done = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == 5);
      M = (i == 5) ? 32'd100 : 32'd0;
      Q = (i == 5) ? 32'd100 : 32'd0;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first_cyc < 0) begin
          first_cyc = i;
          p_at_done = P;
        end
      end
    end
    check("repulse done count", 64'(ndone), 64'd1);
    check("repulse latency", 64'(first_cyc), 64'd32);
    check("repulse P", p_at_done, 64'd42);
    check("repulse idle after", 64'(busy), 64'd0);

    // reset in the middle of a run aborts it
    @(negedge clk);
    start = 1'b1;
    M = 32'd5;
    Q = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort P", P, 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    do_op("after abort", -32'sd7, 32'd9, -64'sd63, 1'b0);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    M = 32'd3;
    Q = -32'sd5;
    @(posedge clk);
    @(negedge clk);
    M = 32'd0;
    Q = 32'd123;
    wait_done(40, cyc);
    check("b2b first latency", 64'(cyc), 64'd32);
    check("b2b first P", P, -64'sd15);
    @(posedge clk);
    #1;
    check("b2b relaunch busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc);
    check("b2b done spacing", 64'(cyc + 1), 64'd33);
    check("b2b second P", P, 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_booth_multiplier
